preg_alloc_ctrl: RTL

// Controls the physical-register free list in the rename stage. Grants one allocation per cycle,

---
 rtl/preg_alloc_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/preg_alloc_ctrl.sv
// Rename-stage physical-register allocation controller.
// Grants one allocation per cycle, returns retired and squashed pregs through
// one free-list enqueue port, and tracks the free-register count.
module preg_alloc_ctrl #(
   parameter int unsigned PREG_W   = 6,
   parameter int unsigned FL_DEPTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alloc_valid_in,
   output logic                             alloc_ready_out,
   output logic [PREG_W-1:0]                alloc_preg_out,
   input  logic                             commit_valid_in,
   input  logic [PREG_W-1:0]                commit_preg_in,
   input  logic                             flush_in,
   input  logic                             squash_valid_in,
   input  logic [PREG_W-1:0]                squash_preg_in,
   output logic                             squash_ready_out,
   input  logic                             squash_done_in,
   output logic                             fl_dequeue_out,
   input  logic [PREG_W-1:0]                fl_rdata_in,
   input  logic                             fl_empty_in,
   output logic                             fl_enqueue_out,
   output logic [PREG_W-1:0]                fl_wdata_out,
   output logic [$clog2(FL_DEPTH):0]        free_count_out,
   output logic                             recovering_out,
   output logic                             overflow_err_out
);

   localparam int unsigned CNT_W = $clog2(FL_DEPTH) + 1;

   localparam logic [0:0] S_RUN     = 1'b0;
   localparam logic [0:0] S_RECOVER = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              r_overflow;
   logic              r_recovering;

   logic              w_alloc_ready;
   logic              w_squash_ready;
   logic              w_dequeue;
   logic              w_enq_req;
   logic [PREG_W-1:0] w_enq_preg;
   logic              w_enqueue;
   logic              w_count_full;
   logic              w_count_zero;

   // State, count and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_RUN;
         r_recovering <= 1'b0;
         r_count      <= CNT_W'(FL_DEPTH);
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_recovering <= (w_state_nxt == S_RECOVER);
         r_count      <= w_count_nxt;
         if (w_enqueue && w_count_full)
            r_overflow <= 1'b1;
      end
   end

   // Next-state, handshakes, enqueue arbitration and count update
   always_comb begin
      w_state_nxt    = r_state;
      w_alloc_ready  = 1'b0;
      w_squash_ready = 1'b0;
      w_dequeue      = 1'b0;
      w_enq_req      = 1'b0;
      w_enq_preg     = '0;
      w_enqueue      = 1'b0;
      w_count_nxt    = r_count;
      w_count_full   = (r_count == CNT_W'(FL_DEPTH));
      w_count_zero   = (r_count == '0);

      case (r_state)
         S_RUN: begin
            // flush cycle never allocates; recovery starts next cycle
            w_alloc_ready = !fl_empty_in && !flush_in;
            if (flush_in)
               w_state_nxt = S_RECOVER;
         end
         S_RECOVER: begin
            // commit owns the enqueue port when both want it
            w_squash_ready = !commit_valid_in;
            if (!flush_in && squash_done_in && (!squash_valid_in || w_squash_ready))
               w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase

      // outputs held quiet while reset is asserted
      if (rst) begin
         w_alloc_ready  = 1'b0;
         w_squash_ready = 1'b0;
      end

      w_dequeue  = alloc_valid_in && w_alloc_ready;
      w_enq_req  = !rst && (commit_valid_in || (squash_valid_in && w_squash_ready));
      w_enq_preg = commit_valid_in ? commit_preg_in : squash_preg_in;
      // x0 is architectural zero, never a free-list entry
      w_enqueue  = w_enq_req && (w_enq_preg != '0);

      if (w_enqueue && !w_dequeue) begin
         if (!w_count_full)
            w_count_nxt = r_count + CNT_W'(1);
      end else if (w_dequeue && !w_enqueue) begin
         if (!w_count_zero)
            w_count_nxt = r_count - CNT_W'(1);
      end
   end

   assign alloc_ready_out  = w_alloc_ready;
   assign alloc_preg_out   = w_alloc_ready ? fl_rdata_in : '0;
   assign fl_dequeue_out   = w_dequeue;
   assign squash_ready_out = w_squash_ready;
   assign fl_enqueue_out   = w_enqueue;
   assign fl_wdata_out     = w_enqueue ? w_enq_preg : '0;
   assign free_count_out   = r_count;
   assign recovering_out   = r_recovering;
   assign overflow_err_out = r_overflow;

endmodule
